// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit placed after the single-cycle core's ALU. It
//            takes the ALU result as the effective address and rs2 as store
//            data. It issues one byte/half/word access to a data memory whose
//            ack latency varies, and it returns an extracted, sign- or
//            zero-extended load value for writeback. While an access is in
//            flight it stalls the core.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT   : number of REQ cycles without mem_ack before the access is
//               abandoned with a fault (1..255)
// Compile-time option
//   LSU_MISALIGN_TRAP_EN : when defined, a misaligned H or W access faults and
//                          is not sent to memory. When undefined, the
//                          offending low address bits are ignored.
// Ports
//   clk, rst         : clock and synchronous active-high reset
//   op_valid         : core presents a load/store (held while stall=1)
//   op_store         : 1 = store, 0 = load
//   op_funct3        : RISC-V width/sign code (B, H, W, BU, HU)
//   op_addr          : effective address
//   op_wdata         : store data (rs2)
//   stall            : core must hold PC and suppress writeback
//   ld_valid         : one-cycle pulse, ld_data valid for writeback
//   ld_data          : extended load result
//   fault            : one-cycle pulse for illegal op, misalign or timeout
//   mem_req          : memory request, held until acknowledged
//   mem_we           : 1 = write
//   mem_addr         : word-aligned address
//   mem_wdata        : lane-replicated store data
//   mem_be           : byte enables, bit n = byte lane n
//   mem_ack          : memory completes the request this cycle
//   mem_rdata        : read word, valid with mem_ack
// ============================================================================
module lsu #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // The wait counter holds (n-1) during the n-th REQ cycle, so the last
    // permitted cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state_q,   w_state_d;
    logic [31:0] r_addr_q,    w_addr_d;
    logic        r_we_q,      w_we_d;
    logic [3:0]  r_be_q,      w_be_d;
    logic [31:0] r_wdata_q,   w_wdata_d;
    logic [1:0]  r_off_q,     w_off_d;
    logic [2:0]  r_f3_q,      w_f3_d;
    logic [7:0]  r_cnt_q,     w_cnt_d;
    logic [31:0] r_ld_data_q, w_ld_data_d;
    logic        r_fault_q,   w_fault_d;   // fault to report in DONE

    // ------------------------------------------------------------------
    // Decode of the operation presented by the core
    // ------------------------------------------------------------------
    logic        w_legal;
    logic        w_misalign;
    logic [3:0]  w_be_new;
    logic [31:0] w_wdata_new;

    always_comb begin
        w_legal = 1'b0;
        case (op_funct3)
            c_F3_B, c_F3_H, c_F3_W: w_legal = 1'b1;
            c_F3_BU, c_F3_HU:       w_legal = ~op_store;  // no unsigned stores
            default:                w_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
                        ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane enables and replicated data. Loads carry the same enables so the
    // memory sees which bytes are being read.
    always_comb begin
        w_be_new    = 4'b1111;
        w_wdata_new = op_wdata;
        case (op_funct3[1:0])
            2'b00: begin
                w_be_new    = 4'b0001 << op_addr[1:0];
                w_wdata_new = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                w_be_new    = op_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_new = {2{op_wdata[15:0]}};
            end
            default: begin
                w_be_new    = 4'b1111;
                w_wdata_new = op_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction from the returned word
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_off_q)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_f3_q)
            c_F3_B:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_ext = {{16{w_half[15]}}, w_half};
            c_F3_BU: w_ext = {24'd0, w_byte};
            c_F3_HU: w_ext = {16'd0, w_half};
            default: w_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_addr_d    = r_addr_q;
        w_we_d      = r_we_q;
        w_be_d      = r_be_q;
        w_wdata_d   = r_wdata_q;
        w_off_d     = r_off_q;
        w_f3_d      = r_f3_q;
        w_cnt_d     = r_cnt_q;
        w_ld_data_d = r_ld_data_q;
        w_fault_d   = r_fault_q;

        case (r_state_q)
            IDLE: begin
                if (op_valid) begin
                    w_addr_d    = {op_addr[31:2], 2'b00};
                    w_we_d      = op_store;
                    w_be_d      = w_be_new;
                    w_wdata_d   = w_wdata_new;
                    w_off_d     = op_addr[1:0];
                    w_f3_d      = op_funct3;
                    w_cnt_d     = 8'd0;
                    w_ld_data_d = 32'd0;
                    if (!w_legal || w_misalign) begin
                        // Rejected without touching memory.
                        w_fault_d = 1'b1;
                        w_state_d = DONE;
                    end else begin
                        w_fault_d = 1'b0;
                        w_state_d = REQ;
                    end
                end
            end

            REQ: begin
                if (mem_ack) begin
                    if (!r_we_q) begin
                        w_ld_data_d = w_ext;
                    end
                    w_state_d = DONE;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_ld_data_d = 32'd0;
                    w_fault_d   = 1'b1;
                    w_state_d   = DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end

            DONE: begin
                // The core advances this cycle; a held op_valid here belongs
                // to the instruction just completed and is not re-captured.
                w_cnt_d   = 8'd0;
                w_fault_d = 1'b0;
                w_state_d = IDLE;
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_addr_q    <= 32'd0;
            r_we_q      <= 1'b0;
            r_be_q      <= 4'd0;
            r_wdata_q   <= 32'd0;
            r_off_q     <= 2'd0;
            r_f3_q      <= 3'd0;
            r_cnt_q     <= 8'd0;
            r_ld_data_q <= 32'd0;
            r_fault_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_we_q      <= w_we_d;
            r_be_q      <= w_be_d;
            r_wdata_q   <= w_wdata_d;
            r_off_q     <= w_off_d;
            r_f3_q      <= w_f3_d;
            r_cnt_q     <= w_cnt_d;
            r_ld_data_q <= w_ld_data_d;
            r_fault_q   <= w_fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall     = op_valid && (r_state_q != DONE);
    assign mem_req   = (r_state_q == REQ);
    assign mem_we    = r_we_q;
    assign mem_addr  = r_addr_q;
    assign mem_wdata = r_wdata_q;
    assign mem_be    = r_be_q;
    assign ld_data   = r_ld_data_q;
    assign ld_valid  = (r_state_q == DONE) && !r_fault_q && !r_we_q;
    assign fault     = (r_state_q == DONE) && r_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Expected access results are queued
//            when an access is driven and popped when the DUT completes it.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_store  (op_store),
        .op_funct3 (op_funct3),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .stall     (stall),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        flt;
        logic        ldv;
        logic [31:0] data;
        int          done_cyc;
        int          req_cyc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        flt;
        logic        ldv;
        logic [31:0] data;
        int          done_cyc;
        int          req_cyc;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        seq_ok;   // stall/req/stability behaviour around the access
        int          stray;    // ld_valid/fault seen outside DONE
    } obs_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(logic flt, logic ldv, logic [31:0] data, int done_cyc,
                                    int req_cyc, logic [31:0] addr, logic [3:0] be,
                                    logic we, logic [31:0] wdata);
        exp_t e;
        e.flt = flt; e.ldv = ldv; e.data = data; e.done_cyc = done_cyc;
        e.req_cyc = req_cyc; e.addr = addr; e.be = be; e.we = we; e.wdata = wdata;
        return e;
    endfunction

    // Drives one access from an IDLE cycle (called at posedge+1) and plays the
    // memory: ack in REQ cycle number ack_lat (0 = never). Holds op_valid
    // through DONE, then returns at posedge+1 of the following IDLE cycle.
    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ack_lat,
                             input logic [31:0] rdata, output obs_t o);
        int c;
        int nreq;
        o.flt = 1'b0; o.ldv = 1'b0; o.data = '0; o.done_cyc = 0; o.req_cyc = 0;
        o.addr = '0; o.be = '0; o.we = 1'b0; o.wdata = '0; o.seq_ok = 1'b1; o.stray = 0;
        op_valid = 1'b1; op_store = st; op_funct3 = f3; op_addr = addr; op_wdata = wdata;
        mem_ack = 1'b0;
        #1;
        if (stall !== 1'b1 || mem_req !== 1'b0) o.seq_ok = 1'b0;
        if (ld_valid !== 1'b0 || fault !== 1'b0) o.stray++;
        c = 1;
        nreq = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            mem_ack = 1'b0;
            if (c > 100) begin
                checks++; errors++;
                $display("FAIL access_bound: no completion after %0d cycles, required <= 100", c);
                break;
            end
            if (mem_req === 1'b1) begin
                nreq++;
                if (nreq == 1) begin
                    o.addr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
                end else if (mem_addr !== o.addr || mem_be !== o.be ||
                             mem_we !== o.we || mem_wdata !== o.wdata) begin
                    o.seq_ok = 1'b0;
                end
                if (stall !== 1'b1) o.seq_ok = 1'b0;
                if (ld_valid !== 1'b0 || fault !== 1'b0) o.stray++;
                if (ack_lat == nreq) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                o.done_cyc = c; o.req_cyc = nreq;
                o.flt = fault; o.ldv = ld_valid; o.data = ld_data;
                if (stall !== 1'b0) o.seq_ok = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        // A re-capture in DONE would show up as a request here.
        if (mem_req !== 1'b0) o.seq_ok = 1'b0;
        if (ld_valid !== 1'b0 || fault !== 1'b0) o.stray++;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_funct3 = 3'd0;
        op_addr = '0; op_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_be !== 4'd0) begin errors++; $display("FAIL rst_mem_be got %h exp 0", mem_be); end
        checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (ld_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_pulses got ldv=%b flt=%b exp 0 0", ld_valid, fault); end
        checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL rst_ld_data got %h exp 0", ld_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b0, 1'b1, 32'hDEAD_BEEF, 3, 1, 32'h104, 4'b1111, 1'b0, 32'h0));
        do_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 1, 32'hDEAD_BEEF, o);
        e = sb.pop_front();
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL lw_addr got %h exp %h", o.addr, e.addr); end
        checks++; if (o.be !== e.be || o.we !== e.we) begin errors++; $display("FAIL lw_be_we got %b/%b exp %b/%b", o.be, o.we, e.be, e.we); end
        checks++; if (o.done_cyc != e.done_cyc || o.req_cyc != e.req_cyc) begin errors++; $display("FAIL lw_latency got %0d/%0d exp %0d/%0d", o.done_cyc, o.req_cyc, e.done_cyc, e.req_cyc); end
        checks++; if (o.ldv !== e.ldv || o.flt !== e.flt || o.data !== e.data) begin errors++; $display("FAIL lw_result got v=%b f=%b %h exp v=%b f=%b %h", o.ldv, o.flt, o.data, e.ldv, e.flt, e.data); end
        checks++; if (o.seq_ok !== 1'b1 || o.stray != 0) begin errors++; $display("FAIL lw_sequence got ok=%b stray=%0d exp 1 0", o.seq_ok, o.stray); end
    endtask

    task automatic test_load_byte();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b0, 1'b1, 32'hFFFF_FF80, 3, 1, 32'h100, 4'b1000, 1'b0, 32'h0));
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h8000_0000, o);
        e = sb.pop_front();
        checks++; if (o.be !== e.be || o.addr !== e.addr) begin errors++; $display("FAIL lb_be_addr got %b %h exp %b %h", o.be, o.addr, e.be, e.addr); end
        checks++; if (o.ldv !== e.ldv || o.data !== e.data) begin errors++; $display("FAIL lb_data got v=%b %h exp v=%b %h", o.ldv, o.data, e.ldv, e.data); end
        sb.push_back(mk_exp(1'b0, 1'b1, 32'h0000_0080, 3, 1, 32'h100, 4'b1000, 1'b0, 32'h0));
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h8000_0000, o);
        e = sb.pop_front();
        checks++; if (o.ldv !== e.ldv || o.data !== e.data || o.seq_ok !== 1'b1) begin errors++; $display("FAIL lbu_data got v=%b %h ok=%b exp v=%b %h ok=1", o.ldv, o.data, o.seq_ok, e.ldv, e.data); end
    endtask

    task automatic test_store();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 6, 4, 32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD));
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 4, 2, 32'h100, 4'b0010, 1'b1, 32'hA5A5_A5A5));
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0, 3, 1, 32'h300, 4'b1111, 1'b1, 32'h1122_3344));
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       do_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 4, 32'h0, o);
                1:       do_access(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 2, 32'h0, o);
                default: do_access(1'b1, 3'b010, 32'h300, 32'h1122_3344, 1, 32'h0, o);
            endcase
            e = sb.pop_front();
            checks++; if (o.we !== e.we || o.be !== e.be || o.addr !== e.addr) begin errors++; $display("FAIL st%0d_we_be_addr got %b %b %h exp %b %b %h", i, o.we, o.be, o.addr, e.we, e.be, e.addr); end
            checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL st%0d_wdata got %h exp %h", i, o.wdata, e.wdata); end
            checks++; if (o.req_cyc != e.req_cyc || o.done_cyc != e.done_cyc) begin errors++; $display("FAIL st%0d_latency got %0d/%0d exp %0d/%0d", i, o.req_cyc, o.done_cyc, e.req_cyc, e.done_cyc); end
            checks++; if (o.ldv !== 1'b0 || o.flt !== 1'b0 || o.seq_ok !== 1'b1 || o.stray != 0) begin errors++; $display("FAIL st%0d_flags got v=%b f=%b ok=%b stray=%0d exp 0 0 1 0", i, o.ldv, o.flt, o.seq_ok, o.stray); end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b1, 1'b0, 32'h0, 17, 15, 32'h500, 4'b1111, 1'b0, 32'h0));
        do_access(1'b0, 3'b010, 32'h500, 32'h0, 0, 32'h0, o);
        e = sb.pop_front();
        checks++; if (o.req_cyc != e.req_cyc || o.done_cyc != e.done_cyc) begin errors++; $display("FAIL timeout_cycles got %0d/%0d exp %0d/%0d", o.req_cyc, o.done_cyc, e.req_cyc, e.done_cyc); end
        checks++; if (o.flt !== e.flt || o.ldv !== e.ldv || o.data !== e.data) begin errors++; $display("FAIL timeout_result got f=%b v=%b %h exp f=%b v=%b %h", o.flt, o.ldv, o.data, e.flt, e.ldv, e.data); end
        checks++; if (o.seq_ok !== 1'b1 || o.stray != 0) begin errors++; $display("FAIL timeout_sequence got ok=%b stray=%0d exp 1 0", o.seq_ok, o.stray); end
    endtask

    task automatic test_illegal();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b1, 1'b0, 32'h0, 2, 0, 32'h0, 4'b0, 1'b0, 32'h0));
        sb.push_back(mk_exp(1'b1, 1'b0, 32'h0, 2, 0, 32'h0, 4'b0, 1'b0, 32'h0));
        for (int i = 0; i < 2; i++) begin
            if (i == 0) do_access(1'b0, 3'b011, 32'h600, 32'h0, 1, 32'h1, o);
            else        do_access(1'b1, 3'b100, 32'h600, 32'h77, 1, 32'h1, o);
            e = sb.pop_front();
            checks++; if (o.flt !== e.flt || o.ldv !== e.ldv || o.req_cyc != e.req_cyc || o.done_cyc != e.done_cyc) begin errors++; $display("FAIL illegal%0d got f=%b v=%b req=%0d done=%0d exp f=%b v=%b req=%0d done=%0d", i, o.flt, o.ldv, o.req_cyc, o.done_cyc, e.flt, e.ldv, e.req_cyc, e.done_cyc); end
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        exp_t e;
`ifdef LSU_MISALIGN_TRAP_EN
        sb.push_back(mk_exp(1'b1, 1'b0, 32'h0, 2, 0, 32'h0, 4'b0, 1'b0, 32'h0));
        sb.push_back(mk_exp(1'b1, 1'b0, 32'h0, 2, 0, 32'h0, 4'b0, 1'b0, 32'h0));
`else
        sb.push_back(mk_exp(1'b0, 1'b1, 32'hFFFF_8765, 3, 1, 32'h100, 4'b0011, 1'b0, 32'h0));
        sb.push_back(mk_exp(1'b0, 1'b1, 32'hCAFE_0123, 4, 2, 32'h100, 4'b1111, 1'b0, 32'h0));
`endif
        for (int i = 0; i < 2; i++) begin
            if (i == 0) do_access(1'b0, 3'b001, 32'h101, 32'h0, 1, 32'h1234_8765, o);
            else        do_access(1'b0, 3'b010, 32'h102, 32'h0, 2, 32'hCAFE_0123, o);
            e = sb.pop_front();
            checks++; if (o.req_cyc != e.req_cyc || o.done_cyc != e.done_cyc) begin errors++; $display("FAIL mis%0d_latency got %0d/%0d exp %0d/%0d", i, o.req_cyc, o.done_cyc, e.req_cyc, e.done_cyc); end
            checks++; if (o.flt !== e.flt || o.ldv !== e.ldv || o.data !== e.data) begin errors++; $display("FAIL mis%0d_result got f=%b v=%b %h exp f=%b v=%b %h", i, o.flt, o.ldv, o.data, e.flt, e.ldv, e.data); end
            if (e.req_cyc != 0) begin
                checks++; if (o.be !== e.be || o.addr !== e.addr) begin errors++; $display("FAIL mis%0d_be_addr got %b %h exp %b %h", i, o.be, o.addr, e.be, e.addr); end
            end
        end
    endtask

    task automatic test_rst_mid();
        op_valid = 1'b1; op_store = 1'b0; op_funct3 = 3'b010; op_addr = 32'h400; mem_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req1 got %b exp 1", mem_req); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        checks++; if (mem_req !== 1'b0 || ld_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rstmid_after got req=%b v=%b f=%b exp 0 0 0", mem_req, ld_valid, fault); end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || ld_valid !== 1'b0 || fault !== 1'b0 || ld_data !== 32'd0) begin errors++; $display("FAIL rstmid_late_ack got req=%b v=%b f=%b %h exp 0 0 0 0", mem_req, ld_valid, fault, ld_data); end
        @(posedge clk); #1;
        checks++; if (ld_valid !== 1'b0 || fault !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got v=%b f=%b req=%b exp 0 0 0", ld_valid, fault, mem_req); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        sb.push_back(mk_exp(1'b0, 1'b1, 32'h0000_9ABC, 3, 1, 32'h204, 4'b1100, 1'b0, 32'h0));
        sb.push_back(mk_exp(1'b0, 1'b1, 32'hFFFF_9ABC, 5, 3, 32'h204, 4'b1100, 1'b0, 32'h0));
        sb.push_back(mk_exp(1'b0, 1'b1, 32'h0000_00FE, 3, 1, 32'h100, 4'b0100, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       do_access(1'b0, 3'b101, 32'h206, 32'h0, 1, 32'h9ABC_0000, o);
                1:       do_access(1'b0, 3'b001, 32'h206, 32'h0, 3, 32'h9ABC_0000, o);
                default: do_access(1'b0, 3'b100, 32'h102, 32'h0, 1, 32'h00FE_0000, o);
            endcase
            e = sb.pop_front();
            checks++; if (o.ldv !== e.ldv || o.data !== e.data || o.be !== e.be || o.addr !== e.addr) begin errors++; $display("FAIL b2b%0d got v=%b %h %b %h exp v=%b %h %b %h", i, o.ldv, o.data, o.be, o.addr, e.ldv, e.data, e.be, e.addr); end
            checks++; if (o.done_cyc != e.done_cyc || o.seq_ok !== 1'b1 || o.stray != 0) begin errors++; $display("FAIL b2b%0d_seq got done=%0d ok=%b stray=%0d exp done=%0d ok=1 stray=0", i, o.done_cyc, o.seq_ok, o.stray, e.done_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store();
        test_timeout();
        test_illegal();
        test_misalign();
        test_rst_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the single-cycle core's ALU: it consumes the ALU result as effective address and the second register operand as store data, performs a byte/half/word access to a data memory with variable ack latency, and returns an extracted, sign- or zero-extended load value for writeback. While an access is in flight it stalls the core so that PC and register writeback hold.

## Interface
- TIMEOUT, 15: max REQ cycles without mem_ack before the access is abandoned (1..255)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  core presents a load/store this cycle; held stable while stall=1
- op_store  in  1  1 = store, 0 = load
- op_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- op_addr  in  32  effective address (ALU output)
- op_wdata  in  32  store data (rs2 value)
- stall  out  1  core must hold PC and suppress writeback
- ld_valid  out  1  one-cycle pulse, ld_data valid for writeback
- ld_data  out  32  extended load result
- fault  out  1  one-cycle pulse: illegal funct3, misaligned (macro), or timeout
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit n = byte lane n
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

## Operation
- FSM states IDLE, REQ, DONE; reset state IDLE.
- IDLE: if op_valid, register mem_addr={op_addr[31:2],2'b00}, mem_we=op_store, mem_be, mem_wdata, lane offset, funct3; go REQ. Illegal funct3 (011,110,111, or store with 1xx): skip memory, set fault, go DONE.
- REQ: mem_req=1, outputs stable; wait counter increments each cycle. On mem_ack: for loads capture extracted data into ld_data; go DONE. If counter reaches TIMEOUT without ack: ld_data=0, fault, go DONE.
- DONE: stall=0; ld_valid=1 for non-faulting loads; fault=1 if flagged; go IDLE.
- stall = op_valid && state!=DONE (combinational).
- Store lanes: B: be=4'b0001<<addr[1:0], wdata={4{byte}}; H: be=addr[1]?1100:0011, wdata={2{half}}; W: be=1111.
- Load extract: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W passthrough.
- mem_ack while mem_req=0 ignored.

## Timing
- Reset values: state IDLE, mem_req/mem_we/mem_be/mem_addr/mem_wdata=0, ld_valid=0, ld_data=0, fault=0, counter=0.
- Minimum access: 3 cycles (IDLE capture, REQ with same-cycle ack, DONE). Ack after k REQ cycles: 2+k cycles.
- mem_req deasserts the cycle after ack is sampled; never two requests back-to-back without an intervening DONE and IDLE.
- Timeout: fault in DONE after exactly TIMEOUT REQ cycles.
- rst mid-access: next cycle IDLE, mem_req=0, no ld_valid/fault; late ack ignored.
- op_valid in DONE not re-captured; core advances that cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 raises fault, no memory request, IDLE->DONE, ld_data=0, no ld_valid.
- Undefined: offending low address bits ignored (H uses addr[1], W aligned down); access proceeds normally, fault never raised for alignment.

## Test plan
- LW addr 0x0000_0104, ack in first REQ cycle, rdata 0xDEAD_BEEF -> mem_addr 0x104, be 1111, ld_valid in cycle 3 with ld_data 0xDEAD_BEEF, stall high cycles 1-2.
- LB addr 0x103, rdata 0x80_00_00_00 -> ld_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x202, wdata 0x1234_ABCD, ack after 4 cycles -> mem_we=1, be 1100, wdata 0xABCD_ABCD, mem_req held 4 cycles, no ld_valid.
- LW, no ack -> fault pulse after 15 REQ cycles, ld_data=0, stall released.
- LH addr 0x101: with macro -> fault, mem_req never asserted; without -> be 0011, access completes.
- rst asserted in 2nd REQ cycle, ack next cycle -> mem_req=0, state IDLE, no ld_valid/fault.
